// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and selects the next PC from reset,
// trap, redirect, return-address stack, halt, stall and sequential increment.
// Optional feature macro: PC_RAS_EN (adds a RAS_DEPTH-entry circular return stack).
module pc_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned          CNT_W        = 32,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             call_valid,
    input  logic             ret_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             halted,
    output logic             misaligned,
    output logic             ras_empty,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [XLEN-1:0] OFFSET_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] STEP        = XLEN'(INSTR_BYTES);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic             valid_q,    valid_d;
    logic             halted_q,   halted_d;
    logic             mis_q,      mis_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             accept_c;
    logic             ras_empty_c;
    logic             ras_pop_c;
    logic [XLEN-1:0]  ras_top_c;

`ifdef PC_RAS_EN
    localparam int unsigned IDX_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [IDX_W-1:0] ras_top_q;
    logic [OCC_W-1:0] ras_occ_q;
    logic             ras_push_c;
    logic             ras_replace_c;
    logic [XLEN-1:0]  ras_link_c;

    assign ras_empty_c   = (ras_occ_q == '0);
    assign ras_top_c     = ras_mem[ras_top_q];
    assign ras_push_c    = call_valid & redirect_valid;
    assign ras_pop_c     = ret_valid & ~trap_valid & ~redirect_valid & ~ras_empty_c;
    assign ras_replace_c = ras_push_c & ret_valid & ~ras_empty_c;
    assign ras_link_c    = pc_q + STEP;

    // Circular return stack; a push when full overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ras_top_q <= '0;
            ras_occ_q <= '0;
        end else if (ras_replace_c) begin
            ras_mem[ras_top_q] <= ras_link_c;
        end else if (ras_push_c) begin
            ras_mem[IDX_W'(ras_top_q + 1'b1)] <= ras_link_c;
            ras_top_q <= IDX_W'(ras_top_q + 1'b1);
            if (ras_occ_q != OCC_W'(RAS_DEPTH)) begin
                ras_occ_q <= OCC_W'(ras_occ_q + 1'b1);
            end
        end else if (ras_pop_c) begin
            ras_top_q <= IDX_W'(ras_top_q - 1'b1);
            ras_occ_q <= OCC_W'(ras_occ_q - 1'b1);
        end
    end
`else
    logic unused_ras_c;

    assign ras_empty_c  = 1'b1;
    assign ras_pop_c    = 1'b0;
    assign ras_top_c    = '0;
    assign unused_ras_c = call_valid ^ ret_valid;
`endif

    assign accept_c = valid_q & fetch_ready & ~stall;

    // Next-state, next-PC and counter selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q + CNT_W'(accept_c);

        case (state_q)
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: if (resume || trap_valid) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (trap_valid) begin
            pc_d = TRAP_VECTOR;
        end else if (redirect_valid) begin
            pc_d  = redirect_target & ~OFFSET_MASK;
            mis_d = (redirect_target & OFFSET_MASK) != '0;
        end else if (ras_pop_c) begin
            pc_d = ras_top_c;
        end else if (accept_c && (state_q == ST_RUN) && !halt_req) begin
            pc_d = pc_q + STEP;
        end

        valid_d  = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc_out      = pc_q;
    assign pc_valid    = valid_q;
    assign halted      = halted_q;
    assign misaligned  = mis_q;
    assign ras_empty   = ras_empty_c;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random traffic, all
// checked against a queue-based behavioural model of the PC unit.
module tb_pc_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 4;
    localparam int unsigned RD   = 4;
    localparam logic [31:0] TV   = 32'h0000_0100;

    logic            clk = 1'b0;
    logic            reset_n, stall, redirect_valid, trap_valid, halt_req, resume;
    logic            call_valid, ret_valid, fetch_ready;
    logic [31:0]     redirect_target;
    logic [31:0]     pc_out;
    logic            pc_valid, halted, misaligned, ras_empty;
    logic [CW-1:0]   fetch_count;

    pc_unit #(.XLEN(XLEN), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TV),
              .CNT_W(CW), .RAS_DEPTH(RD)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap_valid(trap_valid), .halt_req(halt_req),
        .resume(resume), .call_valid(call_valid), .ret_valid(ret_valid),
        .fetch_ready(fetch_ready), .pc_out(pc_out), .pc_valid(pc_valid), .halted(halted),
        .misaligned(misaligned), .ras_empty(ras_empty), .fetch_count(fetch_count));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   pc;
        logic          valid;
        logic          halted;
        logic          mis;
        logic          empty;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    logic [31:0]   m_pc    = 32'h0;
    logic          m_valid = 1'b0;
    logic          m_halt  = 1'b0;
    logic          m_mis   = 1'b0;
    logic [CW-1:0] m_cnt   = '0;
    logic [31:0]   m_ras[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic model_empty();
`ifdef PC_RAS_EN
        return m_ras.size() == 0;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input logic rn, input logic st, input logic rv, input logic [31:0] tg,
                        input logic tv, input logic hr, input logic rs, input logic cv,
                        input logic rt, input logic fr);
        logic        acc, emp;
        logic [31:0] npc, top, link;
        reset_n = rn; stall = st; redirect_valid = rv; redirect_target = tg;
        trap_valid = tv; halt_req = hr; resume = rs; call_valid = cv;
        ret_valid = rt; fetch_ready = fr;
        emp = model_empty();
        top = 32'h0;
`ifdef PC_RAS_EN
        if (!emp) top = m_ras[m_ras.size() - 1];
`endif
        if (!rn) begin
            m_pc = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = '0;
            m_ras.delete();
        end else begin
            acc  = m_valid & fr & ~st;
            link = m_pc + 32'd4;
            if (tv)                            npc = TV;
            else if (rv)                       npc = {tg[31:2], 2'b00};
            else if (rt && !emp)               npc = top;
            else if (acc && !m_halt && !hr)    npc = m_pc + 32'd4;
            else                               npc = m_pc;
`ifdef PC_RAS_EN
            if (cv && rv) begin
                if (rt && !emp) m_ras[m_ras.size() - 1] = link;
                else begin
                    m_ras.push_back(link);
                    if (m_ras.size() > RD) void'(m_ras.pop_front());
                end
            end else if (rt && !tv && !rv && !emp) begin
                void'(m_ras.pop_back());
            end
`endif
            m_mis   = rv && !tv && (tg[1:0] != 2'b00);
            m_halt  = m_halt ? !(rs || tv) : hr;
            m_valid = !m_halt;
            m_cnt   = CW'(m_cnt + CW'(acc));
            m_pc    = npc;
        end
        sb.push_back('{pc: m_pc, valid: m_valid, halted: m_halt, mis: m_mis,
                       empty: model_empty(), cnt: m_cnt});
        @(negedge clk);
    endtask

    task automatic idle(input logic fr);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fr);
    endtask

    task automatic redir(input logic [31:0] tg, input logic st, input logic cv);
        step(1'b1, st, 1'b1, tg, 1'b0, 1'b0, 1'b0, cv, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pop one expectation per clock and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc_out",      pc_out,               e.pc);
                chk("pc_valid",    32'(pc_valid),        32'(e.valid));
                chk("halted",      32'(halted),          32'(e.halted));
                chk("misaligned",  32'(misaligned),      32'(e.mis));
                chk("ras_empty",   32'(ras_empty),       32'(e.empty));
                chk("fetch_count", 32'(fetch_count),     32'(e.cnt));
            end
        end
    end

    initial begin
        logic        st, rv, tv, hr, rs, cv, rt, fr, rn;
        logic [31:0] tg;

        // Reset then sequential fetch with a stall window
        do_reset();
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_valid", 32'(pc_valid), 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("seq_pc8", pc_out, 32'h8);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall_pc", pc_out, 32'h8);
        chk("stall_cnt", 32'(fetch_count), 32'd2);
        idle(1'b1);
        chk("unstall_pc", pc_out, 32'hC);
        chk("seq_cnt3", 32'(fetch_count), 32'd3);

        // Redirect under stall, misaligned redirect
        redir(32'h40, 1'b1, 1'b0);
        chk("redir_pc", pc_out, 32'h40);
        redir(32'h42, 1'b0, 1'b0);
        chk("misal_pc", pc_out, 32'h40);
        chk("misal_flag", 32'(misaligned), 32'd1);
        idle(1'b0);
        chk("misal_pulse", 32'(misaligned), 32'd0);

        // Trap beats redirect; halt and resume
        step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("trap_pc", pc_out, TV);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("halt_valid", 32'(pc_valid), 32'd0);
        chk("halt_flag", 32'(halted), 32'd1);
        idle(1'b1);
        chk("halt_hold", pc_out, TV);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("resume_flag", 32'(halted), 32'd0);
        idle(1'b1);
        chk("resume_inc", pc_out, 32'h104);

        // PC wrap and counter wrap
        redir(32'hFFFF_FFFC, 1'b0, 1'b0);
        idle(1'b1);
        chk("pc_wrap", pc_out, 32'h0);
        do_reset();
        idle(1'b1);
        repeat (16) idle(1'b1);
        chk("cnt_wrap", 32'(fetch_count), 32'd0);
        chk("cnt_wrap_pc", pc_out, 32'h40);

`ifdef PC_RAS_EN
        // Call/return through the stack
        do_reset();
        idle(1'b0);
        redir(32'h10, 1'b0, 1'b0);
        redir(32'h80, 1'b0, 1'b1);
        chk("call_pc", pc_out, 32'h80);
        chk("call_nonempty", 32'(ras_empty), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ret_pc", pc_out, 32'h14);
        chk("ret_empty", 32'(ras_empty), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ret_empty_inc", pc_out, 32'h18);
`else
        chk("ras_tied", 32'(ras_empty), 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rn = ($urandom_range(99) != 0);
            st = ($urandom_range(4) == 0);
            rv = ($urandom_range(6) == 0);
            tv = ($urandom_range(29) == 0);
            hr = ($urandom_range(19) == 0);
            rs = ($urandom_range(3) == 0);
            cv = ($urandom_range(1) == 0);
            rt = ($urandom_range(7) == 0);
            fr = ($urandom_range(4) != 0);
            tg = $urandom;
            if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
            if (tv) begin
                tg[1:0] = 2'b00;
                cv      = 1'b0;
            end
            step(rn, st, rv, tg, tv, hr, rs, cv, rt, fr);
        end

        idle(1'b0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
